// File: rtl/clink_max_min_reducer.sv
// rtl/clink_max_min_reducer.sv - complete-linkage reducer: min over groups of the per-group max distance
module clink_max_min_reducer #(
    parameter int DIST_WIDTH = 32,
    parameter int IDX_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  s_dist_valid,
    output logic                  s_dist_ready,
    input  logic [DIST_WIDTH-1:0] s_dist_data,
    input  logic                  s_dist_last_group,
    input  logic                  s_dist_last_all,
    output logic                  m_res_valid,
    input  logic                  m_res_ready,
    output logic [DIST_WIDTH-1:0] m_res_dist,
    output logic [IDX_WIDTH-1:0]  m_res_idx,
    output logic [IDX_WIDTH:0]    m_res_groups,
    output logic                  m_res_overflow,
    output logic                  busy
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH:0] CNT_ONE = {{IDX_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [DIST_WIDTH-1:0] grp_max_q;
    logic                  grp_open_q;
    logic [DIST_WIDTH-1:0] best_q, best_d;
    logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
    logic                  have_best_q;
    logic [IDX_WIDTH:0]    grp_cnt_q, grp_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q;
    logic [DIST_WIDTH-1:0] res_dist_q;
    logic [IDX_WIDTH-1:0]  res_idx_q;
    logic [IDX_WIDTH:0]    res_groups_q;
    logic                  res_ovf_q;

    logic                  beat;
    logic                  close_grp;
    logic [DIST_WIDTH-1:0] cand;
    logic                  take;

    always_comb begin
        beat      = s_dist_valid && (state_q == ST_ACCUM);
        close_grp = s_dist_last_group || s_dist_last_all;
        cand      = (grp_open_q && (grp_max_q > s_dist_data)) ? grp_max_q : s_dist_data;
        // Strict less-than so ties keep the earlier group
        take       = !have_best_q || (cand < best_q);
        best_d     = take ? cand : best_q;
        best_idx_d = take ? grp_cnt_q[IDX_WIDTH-1:0] : best_idx_q;
        grp_cnt_d  = grp_cnt_q + CNT_ONE;
        // A closing group whose index needs bit IDX_WIDTH no longer fits m_res_idx
        ovf_d      = ovf_q || grp_cnt_q[IDX_WIDTH];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (beat && s_dist_last_all) state_d = ST_HOLD;
            ST_HOLD:  if (m_res_ready) state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= ST_ACCUM;
            grp_max_q    <= '0;
            grp_open_q   <= 1'b0;
            best_q       <= '0;
            best_idx_q   <= '0;
            have_best_q  <= 1'b0;
            grp_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
            res_dist_q   <= '0;
            res_idx_q    <= '0;
            res_groups_q <= '0;
            res_ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (beat) begin
                busy_q <= 1'b1;
                if (close_grp) begin
                    grp_open_q  <= 1'b0;
                    grp_max_q   <= '0;
                    have_best_q <= 1'b1;
                    best_q      <= best_d;
                    best_idx_q  <= best_idx_d;
                    grp_cnt_q   <= grp_cnt_d;
                    ovf_q       <= ovf_d;
                end else begin
                    grp_open_q <= 1'b1;
                    grp_max_q  <= cand;
                end
                if (s_dist_last_all) begin
                    res_dist_q   <= best_d;
                    res_idx_q    <= best_idx_d;
                    res_groups_q <= grp_cnt_d;
                    res_ovf_q    <= ovf_d;
                end
            end
            // Result handshake: clear the pass, but leave the m_res_* registers as they were
            if ((state_q == ST_HOLD) && m_res_ready) begin
                grp_open_q  <= 1'b0;
                grp_max_q   <= '0;
                have_best_q <= 1'b0;
                best_q      <= '0;
                best_idx_q  <= '0;
                grp_cnt_q   <= '0;
                ovf_q       <= 1'b0;
                busy_q      <= 1'b0;
            end
        end
    end

    assign s_dist_ready   = (state_q == ST_ACCUM);
    assign m_res_valid    = (state_q == ST_HOLD);
    assign m_res_dist     = res_dist_q;
    assign m_res_idx      = res_idx_q;
    assign m_res_groups   = res_groups_q;
    assign m_res_overflow = res_ovf_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_clink_max_min_reducer.sv
// tb/tb_clink_max_min_reducer.sv - directed bench for clink_max_min_reducer
module tb_clink_max_min_reducer;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        s_valid, s_ready, s_lg, s_la;
    logic [31:0] s_data;
    logic        r_valid, r_ready, r_ovf, dut_busy;
    logic [31:0] r_dist;
    logic [15:0] r_idx;
    logic [16:0] r_groups;

    logic        o_valid, o_ready_s, o_lg, o_la;
    logic [31:0] o_data;
    logic        o_rvalid, o_rready, o_ovf, o_busy;
    logic [31:0] o_dist;
    logic [1:0]  o_idx;
    logic [2:0]  o_groups;

    int total = 0;
    int bad   = 0;

    clink_max_min_reducer u_dut (
        .ACLK(clk), .ARESET(rst),
        .s_dist_valid(s_valid), .s_dist_ready(s_ready), .s_dist_data(s_data),
        .s_dist_last_group(s_lg), .s_dist_last_all(s_la),
        .m_res_valid(r_valid), .m_res_ready(r_ready), .m_res_dist(r_dist),
        .m_res_idx(r_idx), .m_res_groups(r_groups), .m_res_overflow(r_ovf),
        .busy(dut_busy)
    );

    clink_max_min_reducer #(.DIST_WIDTH(32), .IDX_WIDTH(2)) u_ovf (
        .ACLK(clk), .ARESET(rst),
        .s_dist_valid(o_valid), .s_dist_ready(o_ready_s), .s_dist_data(o_data),
        .s_dist_last_group(o_lg), .s_dist_last_all(o_la),
        .m_res_valid(o_rvalid), .m_res_ready(o_rready), .m_res_dist(o_dist),
        .m_res_idx(o_idx), .m_res_groups(o_groups), .m_res_overflow(o_ovf),
        .busy(o_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic lg, input logic la);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_lg = lg; s_la = la;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_lg = 1'b0; s_la = 1'b0;
    endtask

    task automatic send_o(input logic [31:0] d, input logic lg, input logic la);
        int n = 0;
        @(negedge clk);
        o_valid = 1'b1; o_data = d; o_lg = lg; o_la = la;
        while (!o_ready_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("send_o_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        o_valid = 1'b0; o_lg = 1'b0; o_la = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_valid = 0; s_data = 0; s_lg = 0; s_la = 0; r_ready = 1'b1;
        o_valid = 0; o_data = 0; o_lg = 0; o_la = 0; o_rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", s_ready, 1);
        chk("rst_valid", r_valid, 0);
        chk("rst_dist", r_dist, 0);
        chk("rst_idx", r_idx, 0);
        chk("rst_groups", r_groups, 0);
        chk("rst_ovf", r_ovf, 0);
        chk("rst_busy", dut_busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // {3,7,5} {4,6} {9}: maxima 7,6,9 -> min 6 at index 1
        send(3, 0, 0);
        chk("t1_busy", dut_busy, 1);
        send(7, 0, 0);
        send(5, 1, 0);
        send(4, 0, 0);
        send(6, 1, 0);
        send(9, 1, 1);
        chk("t1_valid", r_valid, 1);
        chk("t1_ready_low", s_ready, 0);
        chk("t1_dist", r_dist, 6);
        chk("t1_idx", r_idx, 1);
        chk("t1_groups", r_groups, 3);
        chk("t1_ovf", r_ovf, 0);
        @(posedge clk);
        #1;
        chk("t1_valid_clr", r_valid, 0);
        chk("t1_ready_back", s_ready, 1);
        chk("t1_busy_clr", dut_busy, 0);
        chk("t1_dist_kept", r_dist, 6);

        // ties: maxima 8,8,8 -> earliest index wins
        send(8, 1, 0);
        send(2, 0, 0);
        send(8, 1, 0);
        send(8, 0, 0);
        send(1, 1, 1);
        chk("t2_valid", r_valid, 1);
        chk("t2_dist", r_dist, 8);
        chk("t2_idx", r_idx, 0);
        chk("t2_groups", r_groups, 3);
        @(posedge clk);
        #1;

        // back-pressure with input hammering while the result is held
        r_ready = 1'b0;
        send(5, 1, 0);
        send(2, 1, 1);
        chk("t3_valid", r_valid, 1);
        @(negedge clk);
        s_valid = 1'b1; s_data = 32'h77; s_lg = 1'b1; s_la = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_ready_low", s_ready, 0);
            chk("t3_valid_hold", r_valid, 1);
            chk("t3_dist_hold", r_dist, 2);
            chk("t3_idx_hold", r_idx, 1);
        end
        s_valid = 1'b0; s_lg = 1'b0; s_la = 1'b0;
        r_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_valid_clr", r_valid, 0);
        chk("t3_groups", r_groups, 2);
        send(32'hFFFF_FFFF, 1, 1);
        chk("t3b_dist", r_dist, 32'hFFFF_FFFF);
        chk("t3b_idx", r_idx, 0);
        chk("t3b_groups", r_groups, 1);
        @(posedge clk);
        #1;

        // last_all without last_group still closes the group
        send(10, 0, 0);
        send(12, 0, 1);
        chk("t4_valid", r_valid, 1);
        chk("t4_dist", r_dist, 12);
        chk("t4_idx", r_idx, 0);
        chk("t4_groups", r_groups, 1);
        @(posedge clk);
        #1;

        // reset mid-pass discards partial data
        send(1, 0, 0);
        send(2, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_busy_rst", dut_busy, 0);
        chk("t5_valid_rst", r_valid, 0);
        chk("t5_dist_rst", r_dist, 0);
        rst = 1'b0;
        send(20, 1, 1);
        chk("t5_valid", r_valid, 1);
        chk("t5_dist", r_dist, 20);
        chk("t5_idx", r_idx, 0);
        chk("t5_groups", r_groups, 1);
        @(posedge clk);
        #1;

        // IDX_WIDTH=2: fifth group has index 4 -> wraps to 0 and flags overflow
        send_o(9, 1, 0);
        send_o(9, 1, 0);
        send_o(9, 1, 0);
        send_o(9, 1, 0);
        send_o(3, 1, 1);
        chk("t6_valid", o_rvalid, 1);
        chk("t6_dist", o_dist, 3);
        chk("t6_idx", o_idx, 0);
        chk("t6_groups", o_groups, 5);
        chk("t6_ovf", o_ovf, 1);
        @(posedge clk);
        #1;
        chk("t6_valid_clr", o_rvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clink_max_min_reducer.md
Name: clink_max_min_reducer

Overview:
- Consumes the per-pair distance stream produced by the distance core.
- Computes complete-linkage cluster distances: the maximum over all point pairs of one cluster pair, called a group.
- Selects the group with the minimum linkage distance and returns its value and index to the merge controller over a valid/ready result port.
- Sits directly downstream of the distance core, in the same ACLK domain.

Parameters:
DIST_WIDTH, 32, width of an unsigned distance word
IDX_WIDTH, 16, width of group index and group counter

Ports:
ACLK  in  1  clock; all logic is rising-edge
ARESET  in  1  reset; synchronous, active-high
s_dist_valid  in  1  input distance beat valid
s_dist_ready  out  1  block accepts a beat
s_dist_data  in  DIST_WIDTH  unsigned pairwise distance
s_dist_last_group  in  1  beat is the final pair of the current group
s_dist_last_all  in  1  beat is the final pair of the final group of the pass
m_res_valid  out  1  result valid
m_res_ready  in  1  consumer accepts result
m_res_dist  out  DIST_WIDTH  minimum of group maxima
m_res_idx  out  IDX_WIDTH  index of the winning group (0-based, order of arrival)
m_res_groups  out  IDX_WIDTH+1  number of groups closed in the pass
m_res_overflow  out  1  group count exceeded 2^IDX_WIDTH in the pass
busy  out  1  at least one beat accepted in the current pass

Behaviour:
- Reset (ARESET=1 at a rising edge) forces:
  - state ACCUM, s_dist_ready=1, m_res_valid=0;
  - m_res_dist=0, m_res_idx=0, m_res_groups=0, m_res_overflow=0, busy=0;
  - all internal accumulators cleared.
- Reset mid-pass or mid-result discards all partial state. No result is emitted for the aborted pass.
- A beat is accepted when s_dist_valid && s_dist_ready.
- State ACCUM: s_dist_ready=1.
  - First beat of a group: grp_max <= data. Later beats: grp_max <= max(grp_max, data), unsigned compare.
  - A beat with last_group=1 closes the group. The candidate is the max including that beat.
  - If no group has closed yet in the pass, or candidate < best (strict), then best <= candidate and best_idx <= grp_cnt.
  - Ties keep the earlier (lower) index.
  - grp_cnt increments by 1 on every close.
  - When grp_cnt would pass 2^IDX_WIDTH-1, best_idx comparisons keep working, the stored index wraps modulo 2^IDX_WIDTH, and the sticky overflow flag is set.
  - A single-beat group (last_group=1 on the group's first beat) is legal; candidate = data.
  - A beat with last_all=1 is treated as last_group=1 whatever its last_group value. After the group closes, the state moves to HOLD.
- State HOLD:
  - Entered on the edge that accepts the last_all beat. m_res_valid=1 from the next cycle, so latency from the last_all beat to result valid is 1 cycle.
  - s_dist_ready=0. Input is ignored.
  - m_res_* hold stable while m_res_valid && !m_res_ready.
  - On m_res_valid && m_res_ready: m_res_valid=0, accumulators and counters clear, busy=0, return to ACCUM. s_dist_ready=1 on the next cycle.
  - m_res_* outputs keep their last values until the next result.
- Outputs m_res_dist, m_res_idx, m_res_groups and m_res_overflow are registered. They update only on entry to HOLD.
- busy is set on the first accepted beat of a pass and clears on the result handshake.
- All comparisons are unsigned, full DIST_WIDTH. No saturation is needed because distances pass through unchanged.

Test Plan:
- Groups {3,7,5}, {4,6}, {9} (last_all on 9), m_res_ready=1 → one cycle after the 9 beat: m_res_valid=1, m_res_dist=6, m_res_idx=1, m_res_groups=3, overflow=0. Ready returns the cycle after the handshake.
- Tie: groups {8}, {2,8}, {8,1} → dist=8, idx=0, groups=3.
- Back-pressure: pass of groups {5},{2}; hold m_res_ready=0 for 10 cycles while driving s_dist_valid=1 → s_dist_ready=0, outputs stable at dist=2, idx=1. After ready, the next pass {0xFFFFFFFF} gives dist=0xFFFFFFFF, idx=0.
- last_all without last_group: beats 10,12 with last_all on 12 and last_group=0 → dist=12, idx=0, groups=1.
- Reset mid-pass: accept {1,2} with no group closed, assert ARESET for 1 cycle, then send {20} with last_all → dist=20, idx=0, groups=1. No result for the aborted data.
- Overflow (IDX_WIDTH=2): 5 single-beat groups 9,9,9,9,3 → dist=3, idx=0 (wrapped 4), groups=5, overflow=1.
